// File: rtl/sophon_tcm_loader.sv
// -----------------------------------------------------------------------------
// sophon_tcm_loader
// Preload engine in front of the SOPHON_TOP external-access port. A
// little-endian byte stream is packed into 32-bit words, each word is written
// through the ext_req/ext_ack handshake, and the core's soft reset is held
// asserted until the whole image has been written.
//
// Ports
//   clk_i, rst_i            : clock, synchronous active-high reset
//   start_i                 : load start pulse (honoured in IDLE, DONE, ERR)
//   base_addr_i, len_i      : first write address (word aligned) and byte count
//   byte_valid_i/_data_i    : input byte stream
//   byte_ready_o            : a byte is accepted this cycle when valid is high
//   ext_req_o/we_o/addr_o/wdata_o, ext_ack_i, ext_error_i : write port
//   busy_o, done_o, error_o : load status
//   core_rst_no             : core soft reset, released only in DONE
// -----------------------------------------------------------------------------
module sophon_tcm_loader #(
    parameter int ACK_TIMEOUT = 1024,
    parameter int TO_W        = 11
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] base_addr_i,
    input  logic [31:0] len_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        ext_req_o,
    output logic        ext_we_o,
    output logic [31:0] ext_addr_o,
    output logic [31:0] ext_wdata_o,
    input  logic        ext_ack_i,
    input  logic        ext_error_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        core_rst_no
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_DONE    = 3'd3,
        S_ERR     = 3'd4
    } state_t;

    // A zero timeout disables the ack watchdog entirely.
    localparam bit              TO_EN   = (ACK_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    state_t          state_q, state_d;
    logic [31:0]     addr_q,  addr_d;
    logic [31:0]     word_q,  word_d;
    logic [1:0]      lane_q,  lane_d;
    logic [31:0]     rem_q,   rem_d;
    logic [TO_W-1:0] to_q,    to_d;

    // Every output is either a flop or a pure decode of the state register,
    // so nothing on the ack or byte-valid inputs reaches an output directly.
    assign byte_ready_o = (state_q == S_COLLECT);
    assign ext_req_o    = (state_q == S_WRITE);
    assign ext_we_o     = (state_q == S_WRITE);
    assign ext_addr_o   = addr_q;
    assign ext_wdata_o  = word_q;
    assign busy_o       = (state_q == S_COLLECT) || (state_q == S_WRITE);
    assign done_o       = (state_q == S_DONE);
    assign error_o      = (state_q == S_ERR);
    assign core_rst_no  = (state_q == S_DONE);

    // Next-state and datapath update for the load sequencer.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        lane_d  = lane_q;
        rem_d   = rem_q;
        to_d    = to_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    addr_d  = {base_addr_i[31:2], 2'b00};
                    rem_d   = len_i;
                    lane_d  = 2'd0;
                    word_d  = 32'd0;
                    to_d    = '0;
                    state_d = (len_i != 32'd0) ? S_COLLECT : S_DONE;
                end else begin
                    state_d = state_q;
                end
            end

            S_COLLECT: begin
                if (byte_valid_i) begin
                    word_d[{lane_q, 3'b000} +: 8] = byte_data_i;
                    lane_d = lane_q + 2'd1;
                    rem_d  = rem_q - 32'd1;
                    // A word is flushed when full or when the image ends;
                    // lanes not yet written stay zero from the last clear.
                    if ((lane_q == 2'd3) || (rem_q == 32'd1)) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end else begin
                    state_d = S_COLLECT;
                end
            end

            S_WRITE: begin
                if (ext_ack_i) begin
                    to_d = '0;
                    if (ext_error_i) begin
                        state_d = S_ERR;
                    end else begin
                        addr_d  = addr_q + 32'd4;
                        lane_d  = 2'd0;
                        word_d  = 32'd0;
                        state_d = (rem_q != 32'd0) ? S_COLLECT : S_DONE;
                    end
                end else if (TO_EN && (to_q == TO_LAST)) begin
                    // This is the ACK_TIMEOUT-th unacknowledged cycle.
                    state_d = S_ERR;
                end else begin
                    to_d = to_q + TO_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            word_q  <= 32'd0;
            lane_q  <= 2'd0;
            rem_q   <= 32'd0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            rem_q   <= rem_d;
            to_q    <= to_d;
        end
    end

endmodule

// File: tb/tb_sophon_tcm_loader.sv
// -----------------------------------------------------------------------------
// tb_sophon_tcm_loader
// Self-checking bench: expected writes {addr,data} are queued when a load is
// set up and popped by the write-port responder on each accepted write.
// -----------------------------------------------------------------------------
module tb_sophon_tcm_loader;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [31:0] len_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        ext_req_o;
    logic        ext_we_o;
    logic [31:0] ext_addr_o;
    logic [31:0] ext_wdata_o;
    logic        ext_ack_i;
    logic        ext_error_i;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic        core_rst_no;

    sophon_tcm_loader #(.ACK_TIMEOUT(16), .TO_W(5)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .len_i        (len_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .ext_req_o    (ext_req_o),
        .ext_we_o     (ext_we_o),
        .ext_addr_o   (ext_addr_o),
        .ext_wdata_o  (ext_wdata_o),
        .ext_ack_i    (ext_ack_i),
        .ext_error_i  (ext_error_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .core_rst_no  (core_rst_no)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  bq[$];
    int          ack_delay = 0;
    bit          ack_en    = 1'b1;
    bit          ack_err   = 1'b0;
    int          mid_idx   = -1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Write-port responder: acks after ack_delay cycles, checks hold stability
    // and compares each accepted write against the scoreboard.
    initial begin : responder
        int          wcnt;
        logic [31:0] h_addr, h_data;
        logic [63:0] e;
        wcnt = 0;
        ext_ack_i = 1'b0;
        ext_error_i = 1'b0;
        forever begin
            @(negedge clk_i);
            ext_ack_i = 1'b0;
            ext_error_i = 1'b0;
            if (ext_req_o && !rst_i) begin
                if (wcnt == 0) begin
                    h_addr = ext_addr_o;
                    h_data = ext_wdata_o;
                end else begin
                    check_eq("addr_stable", ext_addr_o, h_addr);
                    check_eq("data_stable", ext_wdata_o, h_data);
                    check_eq("ready_low_in_write", byte_ready_o, 1'b0);
                end
                if (ack_en && wcnt >= ack_delay) begin
                    ext_ack_i = 1'b1;
                    ext_error_i = ack_err;
                    wcnt = 0;
                    check_eq("we_with_req", ext_we_o, 1'b1);
                    if (!ack_err) begin
                        if (exp_q.size() == 0) begin
                            check_eq("unexpected_write", {ext_addr_o, ext_wdata_o}, 64'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check_eq("wr_addr", ext_addr_o, e[63:32]);
                            check_eq("wr_data", ext_wdata_o, e[31:0]);
                        end
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic do_start(input logic [31:0] base, input logic [31:0] len);
        @(negedge clk_i);
        start_i = 1'b1;
        base_addr_i = base;
        len_i = len;
        @(negedge clk_i);
        start_i = 1'b0;
        check_eq("start_ready", byte_ready_o, (len != 32'd0));
        check_eq("start_done", done_o, (len == 32'd0));
        check_eq("start_err_clr", error_o, 1'b0);
    endtask

    // Drain bq onto the stream, back-to-back when the DUT is ready.
    task automatic send_all();
        int i;
        int n;
        i = 0;
        while (bq.size() != 0) begin
            byte_valid_i = 1'b1;
            byte_data_i = bq.pop_front();
            if (i == mid_idx) begin
                start_i = 1'b1;
                base_addr_i = 32'h1234_5678;
                len_i = 32'd3;
            end
            n = 0;
            while (!byte_ready_o && n < 200) begin
                @(negedge clk_i);
                n++;
            end
            if (n >= 200) check_eq("byte_accept_timeout", 1'b1, 1'b0);
            @(posedge clk_i);
            #1;
            start_i = 1'b0;
            i++;
        end
        byte_valid_i = 1'b0;
        mid_idx = -1;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done_o || error_o) && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        check_eq("end_reached", (n < 300), 1'b1);
    endtask

    initial begin
        int n;
        rst_i = 1'b1;
        start_i = 1'b0;
        base_addr_i = 32'd0;
        len_i = 32'd0;
        byte_valid_i = 1'b0;
        byte_data_i = 8'd0;
        repeat (3) @(negedge clk_i);
        check_eq("rst_flags", {byte_ready_o, ext_req_o, ext_we_o, busy_o, done_o, error_o, core_rst_no}, 7'd0);
        check_eq("rst_addr", ext_addr_o, 32'd0);
        check_eq("rst_wdata", ext_wdata_o, 32'd0);
        rst_i = 1'b0;

        // Two full words, immediate ack.
        do_start(32'h8000_0000, 32'd8);
        check_eq("busy_collect", busy_o, 1'b1);
        exp_q.push_back({32'h8000_0000, 32'h0000_0013});
        exp_q.push_back({32'h8000_0004, 32'h0000_006F});
        bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        send_all();
        @(negedge clk_i);
        check_eq("last_req", ext_req_o, 1'b1);
        check_eq("core_rst_held", core_rst_no, 1'b0);
        @(negedge clk_i);
        check_eq("t1_done", {done_o, core_rst_no, busy_o}, 3'b110);

        // Partial final word is zero-padded.
        do_start(32'h0000_1000, 32'd5);
        exp_q.push_back({32'h0000_1000, 32'h0403_0201});
        exp_q.push_back({32'h0000_1004, 32'h0000_00AB});
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAB};
        send_all();
        wait_end();
        check_eq("t2_done", {done_o, error_o}, 2'b10);

        // Zero length completes immediately with no write.
        do_start(32'h0000_2000, 32'd0);
        repeat (3) begin
            @(negedge clk_i);
            check_eq("len0_no_req", ext_req_o, 1'b0);
        end
        check_eq("len0_done", done_o, 1'b1);

        // Delayed ack, held valid, unaligned base, start ignored mid-load.
        ack_delay = 3;
        do_start(32'h8000_0002, 32'd8);
        check_eq("core_rst_drop", core_rst_no, 1'b0);
        exp_q.push_back({32'h8000_0000, 32'hDDCC_BBAA});
        exp_q.push_back({32'h8000_0004, 32'h4433_2211});
        bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
        mid_idx = 2;
        send_all();
        wait_end();
        check_eq("t4_done", done_o, 1'b1);
        ack_delay = 0;

        // Error on ack, then recovery.
        ack_err = 1'b1;
        do_start(32'h0000_3000, 32'd4);
        bq = '{8'h5A, 8'h5B, 8'h5C, 8'h5D};
        send_all();
        wait_end();
        check_eq("err_flags", {error_o, done_o, core_rst_no}, 3'b100);
        ack_err = 1'b0;
        do_start(32'h0000_3100, 32'd4);
        exp_q.push_back({32'h0000_3100, 32'h0D0C_0B0A});
        bq = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        send_all();
        wait_end();
        check_eq("recover_done", {error_o, done_o}, 2'b01);

        // Ack timeout after 16 write cycles.
        ack_en = 1'b0;
        do_start(32'h0000_5000, 32'd4);
        bq = '{8'h01, 8'h01, 8'h01, 8'h01};
        send_all();
        n = 0;
        while (!error_o && n < 100) begin
            @(negedge clk_i);
            if (ext_req_o) n++;
        end
        check_eq("timeout_cycles", n, 16);
        check_eq("timeout_err", {error_o, core_rst_no}, 2'b10);

        // Reset in WRITE, then reload.
        do_start(32'h0000_6000, 32'd4);
        bq = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
        send_all();
        @(negedge clk_i);
        check_eq("pre_rst_req", ext_req_o, 1'b1);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_eq("midrst_flags", {byte_ready_o, ext_req_o, ext_we_o, busy_o, done_o, error_o, core_rst_no}, 7'd0);
        check_eq("midrst_addr", ext_addr_o, 32'd0);
        check_eq("midrst_wdata", ext_wdata_o, 32'd0);
        rst_i = 1'b0;
        ack_en = 1'b1;
        do_start(32'h0000_6000, 32'd4);
        exp_q.push_back({32'h0000_6000, 32'hF4F3_F2F1});
        bq = '{8'hF1, 8'hF2, 8'hF3, 8'hF4};
        send_all();
        wait_end();
        check_eq("reload_done", done_o, 1'b1);

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
